// File: rtl/bwt_pkg.sv
// Shared pixel and column types for the column generator, word FIFO and downstream stages.
package bwt_pkg;

  localparam int unsigned B      = 8;
  localparam int unsigned COLUMN = 3;

  typedef logic [B-1:0]          pixel_t;
  typedef pixel_t [COLUMN-1:0]   column_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: single-port write, combinational read at the same address.
module line_buffer #(
  parameter int unsigned B     = bwt_pkg::B,
  parameter int unsigned DEPTH = 640,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [B-1:0]  wdata,
  output logic [B-1:0]  rdata
);

  logic [B-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/column_gen.sv
// Raster pixel stream to vertical 3-pixel columns {y, y-1, y-2}, feeding the word FIFO under its full flag.
module column_gen #(
  parameter int unsigned B      = bwt_pkg::B,
  parameter int unsigned COLUMN = bwt_pkg::COLUMN,
  parameter int unsigned IMG_W  = 640
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [B-1:0]                in_data,
  output logic                        in_ready,
  input  logic                        full,
  output logic                        wr,
  output logic [COLUMN-1:0][B-1:0]    w_data,
  output logic                        primed,
  output logic                        sync_err
);

  localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [1:0]    Y_TOP  = 2'd2;

  logic [XW-1:0] x, eff_x, x_nxt;
  logic [1:0]    y, eff_y, y_nxt;
  logic          accept, make_col;
  logic [B-1:0]  lb0_q, lb1_q;

  // The output slot is free when empty or when the FIFO takes the word this cycle.
  assign in_ready = ~wr | ~full;
  assign accept   = in_valid & in_ready;
  assign primed   = (y == Y_TOP);

  // A start-of-frame pixel is position (0,0) regardless of where the counters stand.
  always_comb begin
    eff_x    = in_sof ? '0 : x;
    eff_y    = in_sof ? 2'd0 : y;
    x_nxt    = eff_x + XW'(1);
    y_nxt    = eff_y;
    if (eff_x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (eff_y == Y_TOP) ? Y_TOP : eff_y + 2'd1;
    end
    make_col = accept & (eff_y == Y_TOP);
  end

  // lb0 holds row y-1, lb1 row y-2; both read the old value before the write shifts rows down.
  line_buffer #(.B(B), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (eff_x),
    .wdata (in_data),
    .rdata (lb0_q)
  );

  line_buffer #(.B(B), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (eff_x),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= 2'd0;
      sync_err <= 1'b0;
      wr       <= 1'b0;
      w_data   <= '0;
    end else begin
      if (accept) begin
        x <= x_nxt;
        y <= y_nxt;
      end
      if (accept && in_sof && (x != '0)) sync_err <= 1'b1;
      // A new column may replace the one draining this cycle; otherwise hold until ~full.
      if (make_col) begin
        wr     <= 1'b1;
        w_data <= {in_data, lb0_q, lb1_q};
      end else if (!full) begin
        wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_column_gen.sv
// Bench for column_gen with a 4-pixel-wide image: directed vectors plus randomized scoreboard run.
module tb_column_gen;

  localparam int unsigned W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic             full = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready, wr, primed, sync_err;
  logic [2:0][7:0]  w_data;

  int checks = 0;
  int errors = 0;

  column_gen #(.B(8), .COLUMN(3), .IMG_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .in_ready (in_ready),
    .full     (full),
    .wr       (wr),
    .w_data   (w_data),
    .primed   (primed),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  function automatic logic [23:0] col_of(input int m);
    return {pix(m / 4, m % 4), pix((m - 4) / 4, (m - 4) % 4), pix((m - 8) / 4, (m - 8) % 4)};
  endfunction

  task automatic drive(input logic v, input logic s, input logic f, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = s;
    full     = f;
    in_data  = d;
  endtask

  // Reference: the image as rows of pixels; a pixel in row >= 2 yields the column above it.
  bit          sb_en = 1'b0;
  int          m_row, m_col;
  bit          m_sync;
  logic [7:0]  img [3][W];
  logic [23:0] exp_q [$];

  function automatic void model_step(input logic s, input logic [7:0] d);
    if (s) begin
      if (m_col != 0) m_sync = 1'b1;
      m_row = 0;
      m_col = 0;
    end
    img[m_row % 3][m_col] = d;
    if (m_row >= 2)
      exp_q.push_back({d, img[(m_row - 1) % 3][m_col], img[(m_row - 2) % 3][m_col]});
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
    end
  endfunction

  always @(negedge clk) begin
    bit pend, rdy;
    if (reset) begin
      m_row = 0;
      m_col = 0;
      m_sync = 1'b0;
      exp_q.delete();
      sb_en = 1'b1;
    end else if (sb_en) begin
      pend = (exp_q.size() != 0);
      rdy  = !(pend && full);
      chk("sb_wr", 32'(wr), 32'(pend));
      chk("sb_in_ready", 32'(in_ready), 32'(rdy));
      chk("sb_primed", 32'(primed), 32'(m_row >= 2));
      chk("sb_sync_err", 32'(sync_err), 32'(m_sync));
      if (pend && !full) chk("sb_column", 32'(w_data), 32'(exp_q.pop_front()));
      if (in_valid && rdy) model_step(in_sof, in_data);
    end
  end

  typedef struct {
    logic        v, s, f;
    logic [7:0]  d;
    logic        ewr, erdy, eprimed;
    logic [23:0] edata;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Rows 0..3 streamed back to back, then two idle cycles to drain.
    for (int t = 0; t < 18; t++) begin
      tbl[t].v       = (t < 16);
      tbl[t].s       = (t == 0);
      tbl[t].f       = 1'b0;
      tbl[t].d       = (t < 16) ? pix(t / 4, t % 4) : 8'h00;
      tbl[t].ewr     = (t >= 9) && (t <= 16);
      tbl[t].edata   = ((t >= 9) && (t <= 16)) ? col_of(t - 1) : 24'h0;
      tbl[t].erdy    = 1'b1;
      tbl[t].eprimed = (t >= 8);
    end

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);

    for (int t = 0; t < 18; t++) begin
      drive(tbl[t].v, tbl[t].s, tbl[t].f, tbl[t].d);
      @(negedge clk);
      chk("vec_wr", 32'(wr), 32'(tbl[t].ewr));
      chk("vec_in_ready", 32'(in_ready), 32'(tbl[t].erdy));
      chk("vec_primed", 32'(primed), 32'(tbl[t].eprimed));
      if (tbl[t].ewr) chk("vec_w_data", 32'(w_data), 32'(tbl[t].edata));
    end

    // Backpressure: column for 0x40 held through a 3-cycle stall, then 0x41 follows with no gap.
    drive(1'b1, 1'b0, 1'b0, pix(4, 0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, pix(4, 1));
      @(negedge clk);
      chk("stall_wr", 32'(wr), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_w_data", 32'(w_data), 32'h403020);
    end
    drive(1'b1, 1'b0, 1'b0, pix(4, 1));
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_w_data", 32'(w_data), 32'h403020);
    drive(1'b1, 1'b0, 1'b0, pix(4, 2));
    @(negedge clk);
    chk("nogap_wr", 32'(wr), 32'd1);
    chk("nogap_w_data", 32'(w_data), 32'h413121);
    drive(1'b1, 1'b0, 1'b0, pix(4, 3));
    drive(1'b1, 1'b0, 1'b0, pix(5, 0));
    drive(1'b1, 1'b0, 1'b0, pix(5, 1));

    // Misaligned start of frame at x=2.
    drive(1'b1, 1'b1, 1'b0, pix(0, 0));
    drive(1'b1, 1'b0, 1'b0, pix(0, 1));
    @(negedge clk);
    chk("sof_sync_err", 32'(sync_err), 32'd1);
    chk("sof_primed", 32'(primed), 32'd0);
    chk("sof_wr", 32'(wr), 32'd0);
    for (int n = 2; n < 9; n++) begin
      drive(1'b1, 1'b0, 1'b0, pix(n / 4, n % 4));
      @(negedge clk);
      chk("reprime_wr", 32'(wr), 32'd0);
      chk("reprime_sync_err", 32'(sync_err), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, pix(2, 1));
    @(negedge clk);
    chk("reprime_col_wr", 32'(wr), 32'd1);
    chk("reprime_col", 32'(w_data), 32'h201000);
    for (int n = 10; n < 14; n++) drive(1'b1, 1'b0, 1'b0, pix(n / 4, n % 4));

    // Reset mid-row 3 with a column pending.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr", 32'(wr), 32'd0);
    chk("mid_rst_w_data", 32'(w_data), 32'd0);
    chk("mid_rst_primed", 32'(primed), 32'd0);
    chk("mid_rst_sync_err", 32'(sync_err), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Fresh frame without in_sof: first pixel counts as (0,0).
    for (int n = 0; n < 12; n++) begin
      drive(1'b1, 1'b0, 1'b0, pix(n / 4, n % 4));
      @(negedge clk);
      if (n == 8) chk("fresh_wr_row1", 32'(wr), 32'd0);
      if (n == 10) chk("fresh_col_x1", 32'(w_data), 32'h211101);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Randomized traffic with stall bursts, stray start-of-frame and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      logic v, s, f;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 40) == 0);
      f = ((c / 50) % 4 == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      drive(v, s, f, 8'($urandom));
      reset = ($urandom_range(0, 700) == 0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("end_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
